tick_scheduler: RTL

Run-time programmable tick scheduler that paces the multiplier datapath. It derives one-cycle `tick` enable pulses from the free-running `osc_clk`, replacing a fixed slow clock. It supports a free-running mode with a selectable period and a single-step mode for bench and board debug. It sits between the board oscillator/switches and the multiplier controller, which advances only on `tick`.

---
 rtl/tick_scheduler_pkg.sv | 22 ++
 rtl/tick_scheduler_if.sv | 32 +++
 rtl/step_debounce.sv | 31 +++
 rtl/tick_scheduler.sv | 133 +++++++++++++
 4 files changed

// File: rtl/tick_scheduler_pkg.sv
// Shared types and helpers for the tick scheduler.
// Build option: TICK_SCHED_DEBOUNCE_EN.
package tick_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STEP,
        STEP_WAIT
    } state_t;

    localparam int RATE_W = 3;

    // Last counter value of a period of 2^(base+rate) cycles.
    function automatic logic [63:0] term_count(
        input int unsigned base,
        input int unsigned rate
    );
        return (64'd1 << (base + rate)) - 64'd1;
    endfunction

endpackage

// File: rtl/tick_scheduler_if.sv
// Control/status bundle between the board inputs, the scheduler
// and the multiplier controller that consumes tick.
interface tick_scheduler_if #(
    parameter int RATE_W = tick_sched_pkg::RATE_W
) ();

    logic              run;
    logic              step_req;
    logic [RATE_W-1:0] rate_sel;
    logic              tick;
    logic              running;
    logic [7:0]        tick_cnt;

    modport master (
        output run,
        output step_req,
        output rate_sel,
        input  tick,
        input  running,
        input  tick_cnt
    );

    modport slave (
        input  run,
        input  step_req,
        input  rate_sel,
        output tick,
        output running,
        output tick_cnt
    );

endinterface

// File: rtl/step_debounce.sv
// Step button filter: output follows the raw input only after it
// has held a new value for 2^DEB_W consecutive cycles.
module step_debounce #(
    parameter int DEB_W = 16
) (
    input  logic osc_clk,
    input  logic nReset,
    input  logic raw,
    output logic filt
);

    logic [DEB_W-1:0] stable_cnt;
    logic             filt_q;

    always_ff @(posedge osc_clk or negedge nReset) begin
        if (!nReset) begin
            stable_cnt <= '0;
            filt_q     <= 1'b0;
        end else if (raw == filt_q) begin
            stable_cnt <= '0;
        end else if (&stable_cnt) begin
            filt_q     <= raw;
            stable_cnt <= '0;
        end else begin
            stable_cnt <= stable_cnt + DEB_W'(1);
        end
    end

    assign filt = filt_q;

endmodule

// File: rtl/tick_scheduler.sv
// Programmable tick pulse generator with free-run and single-step modes.
// Build option: TICK_SCHED_DEBOUNCE_EN adds a step_req debouncer.
module tick_scheduler #(
    parameter int BASE   = 14,
    parameter int RATE_W = tick_sched_pkg::RATE_W
`ifdef TICK_SCHED_DEBOUNCE_EN
    ,
    parameter int DEB_W  = 16
`endif
) (
    input  logic           osc_clk,
    input  logic           nReset,
    tick_scheduler_if.slave bus
);

    import tick_sched_pkg::*;

    localparam int CW = BASE + 2**RATE_W - 1;

    state_t            state;
    state_t            state_nx;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_nx;
    logic [CW-1:0]     tc;
    logic [RATE_W-1:0] rate_q;
    logic              step_sig;
    logic              step_q;
    logic              step_edge_q;
    logic              at_tc;
    logic              issue;
    logic              latch_rate;
    logic              tick_q;
    logic              running_q;
    logic [7:0]        tick_cnt_q;

`ifdef TICK_SCHED_DEBOUNCE_EN
    step_debounce #(
        .DEB_W(DEB_W)
    ) u_deb (
        .osc_clk(osc_clk),
        .nReset (nReset),
        .raw    (bus.step_req),
        .filt   (step_sig)
    );
`else
    assign step_sig = bus.step_req;
`endif

    assign tc = CW'(term_count(BASE, 32'(rate_q)));

    always_ff @(posedge osc_clk or negedge nReset) begin
        if (!nReset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (bus.run) begin
                    state_nx = RUN;
                end else if (step_edge_q) begin
                    state_nx = STEP;
                end
            end
            RUN: begin
                if (!bus.run) begin
                    state_nx = IDLE;
                end
            end
            STEP: begin
                state_nx = STEP_WAIT;
            end
            STEP_WAIT: begin
                if (!step_sig) begin
                    state_nx = bus.run ? RUN : IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // A tick landing on the stop edge is still delivered.
    always_comb begin
        at_tc      = (state == RUN) && (count == tc);
        issue      = at_tc || (state == STEP);
        latch_rate = issue || ((state != RUN) && (state_nx == RUN));
        count_nx   = '0;
        if ((state == RUN) && bus.run && !at_tc) begin
            count_nx = count + CW'(1);
        end
    end

    always_ff @(posedge osc_clk or negedge nReset) begin
        if (!nReset) begin
            step_q      <= 1'b0;
            step_edge_q <= 1'b0;
        end else begin
            step_q      <= step_sig;
            step_edge_q <= step_sig & ~step_q;
        end
    end

    always_ff @(posedge osc_clk or negedge nReset) begin
        if (!nReset) begin
            count      <= '0;
            rate_q     <= '0;
            tick_q     <= 1'b0;
            running_q  <= 1'b0;
            tick_cnt_q <= '0;
        end else begin
            count     <= count_nx;
            tick_q    <= issue;
            running_q <= (state == RUN);
            if (latch_rate) begin
                rate_q <= bus.rate_sel;
            end
            if (issue) begin
                tick_cnt_q <= tick_cnt_q + 8'd1;
            end
        end
    end

    assign bus.tick     = tick_q;
    assign bus.running  = running_q;
    assign bus.tick_cnt = tick_cnt_q;

endmodule
